// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, types and helpers used by the fetch stage and IF/ID register.
package mips_pkg;

    localparam int          WORD_W     = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
    localparam int unsigned IMEM_WORDS = 1024;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_REDIRECT = 2'd1,
        PC_SEQ      = 2'd2
    } pc_sel_e;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t pc8;
        logic  valid;
    } if_id_t;

    // One extra bit keeps base + 4*words from wrapping when the window sits at the top of memory.
    function automatic logic fetch_addr_ok(input word_t pc, input word_t base,
                                           input int unsigned words);
        logic [WORD_W:0] w_pc;
        logic [WORD_W:0] w_lo;
        logic [WORD_W:0] w_hi;
        w_pc = {1'b0, pc};
        w_lo = {1'b0, base};
        w_hi = w_lo + ({1'b0, words} << 2);
        return (pc[1:0] == 2'b00) && (w_pc >= w_lo) && (w_pc < w_hi);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble (and wins over stall), stall holds, otherwise capture.
// With IFU_ADDR_CHECK_EN defined it also carries the address-error flag id_exc_adel.
module if_id_reg #(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_pc8,
`ifdef IFU_ADDR_CHECK_EN
    input  logic        fetch_exc,
    output logic        id_exc_adel,
`endif
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid
);
    import mips_pkg::*;

    if_id_t r_q;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '{instr: NOP_INSTR, pc: RESET_PC, pc8: RESET_PC + 32'd8, valid: 1'b0};
        end else if (flush) begin
            r_q <= '{instr: NOP_INSTR, pc: fetch_pc, pc8: fetch_pc8, valid: 1'b0};
        end else if (!stall) begin
            r_q <= '{instr: fetch_instr, pc: fetch_pc, pc8: fetch_pc8, valid: 1'b1};
        end
    end

`ifdef IFU_ADDR_CHECK_EN
    logic r_exc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exc <= 1'b0;
        end else if (flush) begin
            r_exc <= 1'b0;
        end else if (!stall) begin
            r_exc <= fetch_exc;
        end
    end

    assign id_exc_adel = r_exc;
`endif

    assign id_instr = r_q.instr;
    assign id_pc    = r_q.pc;
    assign id_pc8   = r_q.pc8;
    assign id_valid = r_q.valid;

endmodule

// File: rtl/ifu_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and IF/ID capture with stall/flush.
// Define IFU_ADDR_CHECK_EN to add fetch-address checking and the id_exc_adel output.
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
`ifdef IFU_ADDR_CHECK_EN
    parameter logic [31:0] IMEM_BASE  = mips_pkg::IMEM_BASE,
    parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS,
`endif
    parameter logic [31:0] NOP_INSTR  = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
`ifdef IFU_ADDR_CHECK_EN
    output logic        id_exc_adel,
`endif
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid
);
    import mips_pkg::*;

    word_t   r_pc;
    word_t   w_next_pc;
    word_t   w_pc_plus4;
    word_t   w_pc_plus8;
    word_t   w_fetch_instr;
    pc_sel_e w_pc_sel;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;
    assign imem_addr  = r_pc;

    // A stalled ID re-presents its redirect later, so stall must mask redirect_en here.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_pc_sel = PC_SEQ;
        if (stall) begin
            w_pc_sel = PC_HOLD;
        end else if (redirect_en) begin
            w_pc_sel = PC_REDIRECT;
        end
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (w_pc_sel)
            PC_HOLD:     w_next_pc = r_pc;
            PC_REDIRECT: w_next_pc = redirect_pc;
            default:     w_next_pc = w_pc_plus4;
        endcase
    end

    // NOTE: only flops get the asynchronous reset; combinational paths follow from them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

`ifdef IFU_ADDR_CHECK_EN
    logic w_fetch_exc;

    always_comb begin
        w_fetch_instr = imem_rdata;
        w_fetch_exc   = 1'b0;
        if (!fetch_addr_ok(r_pc, IMEM_BASE, IMEM_WORDS)) begin
            w_fetch_instr = NOP_INSTR;
            w_fetch_exc   = 1'b1;
        end
    end
`else
    assign w_fetch_instr = imem_rdata;
`endif

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .fetch_instr (w_fetch_instr),
        .fetch_pc    (r_pc),
        .fetch_pc8   (w_pc_plus8),
`ifdef IFU_ADDR_CHECK_EN
        .fetch_exc   (w_fetch_exc),
        .id_exc_adel (id_exc_adel),
`endif
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc8      (id_pc8),
        .id_valid    (id_valid)
    );

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Self-checking bench for ifu_fetch_stage against a cycle-level reference model of the fetch rules.
module tb_ifu_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;
    logic        id_exc_adel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the PC and the instruction record that ID should see.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_pc8;
    logic        m_valid;
    logic        m_exc;

    ifu_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
`ifdef IFU_ADDR_CHECK_EN
        .id_exc_adel (id_exc_adel),
`endif
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc8      (id_pc8),
        .id_valid    (id_valid)
    );

`ifndef IFU_ADDR_CHECK_EN
    assign id_exc_adel = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h3C01_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef IFU_ADDR_CHECK_EN
        return (a % 4 != 0) || (a < 32'h0000_3000) || (a >= 32'h0000_3000 + 4 * 1024);
`else
        return (a != a);
`endif
    endfunction

    task automatic model_reset();
        m_pc     = 32'h0000_3000;
        m_instr  = 32'h0;
        m_id_pc  = 32'h0000_3000;
        m_id_pc8 = 32'h0000_3008;
        m_valid  = 1'b0;
        m_exc    = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model by the fetch rules, samples 1 time unit after the edge.
    task automatic cycle(input logic s, input logic f, input logic re, input logic [31:0] rpc);
        logic [31:0] fetched;
        logic        bad;
        stall       = s;
        flush       = f;
        redirect_en = re;
        redirect_pc = rpc;
        bad     = addr_bad(m_pc);
        fetched = bad ? 32'h0 : mem_word(m_pc);
        @(posedge clk);
        if (f) begin
            m_instr  = 32'h0;
            m_valid  = 1'b0;
            m_exc    = 1'b0;
            m_id_pc  = m_pc;
            m_id_pc8 = m_pc + 32'd8;
        end else if (!s) begin
            m_instr  = fetched;
            m_valid  = 1'b1;
            m_exc    = bad;
            m_id_pc  = m_pc;
            m_id_pc8 = m_pc + 32'd8;
        end
        if (!s) m_pc = re ? rpc : m_pc + 32'd4;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #12;
        n_checks++;
        if (imem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", imem_addr, 32'h0000_3000); end
        n_checks++;
        if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", id_instr, 32'h0); end
        n_checks++;
        if (id_pc !== 32'h0000_3000 || id_pc8 !== 32'h0000_3008) begin
            n_fail++; $display("FAIL reset_id_pc: got %h/%h want 00003000/00003008", id_pc, id_pc8);
        end
        n_checks++;
        if (id_valid !== 1'b0 || id_exc_adel !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got valid=%b exc=%b want 0/0", id_valid, id_exc_adel);
        end
        reset = 1'b1;
        cycle(0, 0, 0, 32'h0);
        n_checks++;
        if (id_pc !== 32'h0000_3000 || id_pc8 !== 32'h0000_3008) begin
            n_fail++; $display("FAIL first_fetch_pc: got %h/%h want 00003000/00003008", id_pc, id_pc8);
        end
        n_checks++;
        if (id_instr !== 32'h3C01_0001 || id_valid !== 1'b1) begin
            n_fail++; $display("FAIL first_fetch_instr: got %h v=%b want 3c010001 v=1", id_instr, id_valid);
        end
        cycle(0, 0, 0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h0000_3008) begin n_fail++; $display("FAIL second_edge_pc: got %h want %h", imem_addr, 32'h0000_3008); end
    endtask

    task automatic test_redirect();
        cycle(0, 0, 1, 32'h0000_3010);
        cycle(0, 0, 1, 32'h0000_3040);
        n_checks++;
        if (imem_addr !== 32'h0000_3040) begin n_fail++; $display("FAIL redirect_pc: got %h want %h", imem_addr, 32'h0000_3040); end
        n_checks++;
        if (id_pc !== 32'h0000_3010 || id_instr !== mem_word(32'h0000_3010) || id_valid !== 1'b1) begin
            n_fail++; $display("FAIL delay_slot: got pc=%h instr=%h v=%b want pc=00003010 instr=%h v=1",
                               id_pc, id_instr, id_valid, mem_word(32'h0000_3010));
        end
        cycle(0, 0, 0, 32'h0);
        n_checks++;
        if (id_pc !== 32'h0000_3040 || id_instr !== mem_word(32'h0000_3040)) begin
            n_fail++; $display("FAIL redirect_target: got pc=%h instr=%h want pc=00003040 instr=%h",
                               id_pc, id_instr, mem_word(32'h0000_3040));
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;
        logic [31:0] hold_id_pc;
        hold_pc    = m_pc;
        hold_instr = m_instr;
        hold_id_pc = m_id_pc;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 32'h0000_3200);
            n_checks++;
            if (imem_addr !== hold_pc || id_instr !== hold_instr || id_pc !== hold_id_pc
                || id_pc8 !== hold_id_pc + 32'd8 || id_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h instr=%h id_pc=%h want pc=%h instr=%h id_pc=%h",
                                   i, imem_addr, id_instr, id_pc, hold_pc, hold_instr, hold_id_pc);
            end
        end
        cycle(0, 0, 1, 32'h0000_3200);
        n_checks++;
        if (imem_addr !== 32'h0000_3200 || id_pc !== hold_pc) begin
            n_fail++; $display("FAIL stall_release: got pc=%h id_pc=%h want pc=00003200 id_pc=%h", imem_addr, id_pc, hold_pc);
        end
    endtask

    task automatic test_flush_stall();
        cycle(0, 0, 1, 32'h0000_3020);
        cycle(1, 1, 0, 32'h0);
        n_checks++;
        if (id_valid !== 1'b0 || id_instr !== 32'h0 || imem_addr !== 32'h0000_3020) begin
            n_fail++; $display("FAIL flush_stall: got v=%b instr=%h pc=%h want v=0 instr=00000000 pc=00003020",
                               id_valid, id_instr, imem_addr);
        end
        cycle(0, 1, 0, 32'h0);
        n_checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0000_3020 || imem_addr !== 32'h0000_3024) begin
            n_fail++; $display("FAIL flush_only: got v=%b id_pc=%h pc=%h want v=0 id_pc=00003020 pc=00003024",
                               id_valid, id_pc, imem_addr);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h want %h", imem_addr, 32'h0); end
        n_checks++;
        if (id_pc !== 32'hFFFF_FFFC || id_pc8 !== 32'h0000_0004) begin
            n_fail++; $display("FAIL pc8_wrap: got %h/%h want fffffffc/00000004", id_pc, id_pc8);
        end
        cycle(0, 0, 1, 32'h0000_3100);
    endtask

    task automatic test_random();
        logic        s, f, re;
        logic [31:0] rpc;
        for (int i = 0; i < 300; i++) begin
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 6) == 0);
            re  = ($urandom_range(0, 3) == 0);
            rpc = 32'h0000_3000 + ($urandom_range(0, 1023) << 2);
`ifdef IFU_ADDR_CHECK_EN
            if ($urandom_range(0, 7) == 0) rpc = $urandom;
`endif
            cycle(s, f, re, rpc);
            n_checks++;
            if (imem_addr !== m_pc || id_instr !== m_instr || id_pc !== m_id_pc || id_pc8 !== m_id_pc8
                || id_valid !== m_valid || id_exc_adel !== m_exc) begin
                n_fail++;
                $display("FAIL random[%0d]: got pc=%h instr=%h id_pc=%h pc8=%h v=%b e=%b want pc=%h instr=%h id_pc=%h pc8=%h v=%b e=%b",
                         i, imem_addr, id_instr, id_pc, id_pc8, id_valid, id_exc_adel,
                         m_pc, m_instr, m_id_pc, m_id_pc8, m_valid, m_exc);
            end
        end
    endtask

    task automatic test_reset_midrun();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (imem_addr !== 32'h0000_3000 || id_instr !== 32'h0 || id_pc !== 32'h0000_3000
            || id_pc8 !== 32'h0000_3008 || id_valid !== 1'b0 || id_exc_adel !== 1'b0) begin
            n_fail++; $display("FAIL reset_midrun: got pc=%h instr=%h id_pc=%h pc8=%h v=%b e=%b want reset values",
                               imem_addr, id_instr, id_pc, id_pc8, id_valid, id_exc_adel);
        end
        model_reset();
        #2;
        reset = 1'b1;
        cycle(0, 0, 0, 32'h0);
        n_checks++;
        if (id_instr !== 32'h3C01_0001 || id_pc !== 32'h0000_3000 || imem_addr !== 32'h0000_3004) begin
            n_fail++; $display("FAIL reset_restart: got instr=%h id_pc=%h pc=%h want 3c010001/00003000/00003004",
                               id_instr, id_pc, imem_addr);
        end
    endtask

`ifdef IFU_ADDR_CHECK_EN
    task automatic test_addr_check();
        cycle(0, 0, 1, 32'h0000_3002);
        cycle(0, 0, 1, 32'h0000_7000);
        n_checks++;
        if (id_exc_adel !== 1'b1 || id_instr !== 32'h0 || id_valid !== 1'b1) begin
            n_fail++; $display("FAIL adel_misaligned: got e=%b instr=%h v=%b want e=1 instr=00000000 v=1",
                               id_exc_adel, id_instr, id_valid);
        end
        cycle(0, 0, 1, 32'h0000_3100);
        n_checks++;
        if (id_exc_adel !== 1'b1 || id_instr !== 32'h0 || id_pc !== 32'h0000_7000) begin
            n_fail++; $display("FAIL adel_range: got e=%b instr=%h id_pc=%h want e=1 instr=00000000 id_pc=00007000",
                               id_exc_adel, id_instr, id_pc);
        end
        cycle(0, 0, 0, 32'h0);
        n_checks++;
        if (id_exc_adel !== 1'b0 || id_instr !== mem_word(32'h0000_3100)) begin
            n_fail++; $display("FAIL adel_clear: got e=%b instr=%h want e=0 instr=%h",
                               id_exc_adel, id_instr, mem_word(32'h0000_3100));
        end
        cycle(0, 0, 1, 32'h0000_3FFC);
        cycle(0, 0, 0, 32'h0);
        cycle(0, 0, 0, 32'h0);
        n_checks++;
        if (id_exc_adel !== 1'b1 || id_pc !== 32'h0000_4000) begin
            n_fail++; $display("FAIL adel_upper_edge: got e=%b id_pc=%h want e=1 id_pc=00004000", id_exc_adel, id_pc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_redirect();
        test_stall_redirect();
        test_flush_stall();
        test_wrap();
        test_random();
        test_reset_midrun();
`ifdef IFU_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
